// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID stage register with valid/ready handshake, one-entry skid buffer, flush and stall counter.
module if_id_skid_reg #(
  parameter int PC_WIDTH = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_INC = 4,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [PC_WIDTH-1:0]    out_pc_next,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [CNT_WIDTH-1:0]   stall_count
);
  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pcn_q, pcn_d, skid_pc_q, skid_pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d, skid_instr_q, skid_instr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic in_xfer, load_in, load_skid, to_skid, drain;
  always_comb begin
    in_xfer = in_valid & ~skid_v_q;
    load_in = ~flush & in_xfer & (~main_v_q | out_ready);
    load_skid = ~flush & main_v_q & out_ready & skid_v_q;
    to_skid = ~flush & in_xfer & main_v_q & ~out_ready;
    drain = ~flush & main_v_q & out_ready & ~skid_v_q & ~in_xfer;
    main_v_d = (flush | drain) ? 1'b0 : ((load_in | load_skid) ? 1'b1 : main_v_q);
    skid_v_d = (flush | load_skid) ? 1'b0 : (to_skid ? 1'b1 : skid_v_q);
    pc_d = load_skid ? skid_pc_q : (load_in ? in_pc : pc_q);
    pcn_d = pc_d + PC_WIDTH'(PC_INC);
    instr_d = (flush | drain) ? NOP_INSTR : (load_skid ? skid_instr_q : (load_in ? in_instr : instr_q));
    skid_pc_d = to_skid ? in_pc : skid_pc_q;
    skid_instr_d = to_skid ? in_instr : skid_instr_q;
    // Saturating: stop once every bit is set.
    cnt_d = (main_v_q & ~out_ready & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      pc_q <= '0;
      pcn_q <= PC_WIDTH'(PC_INC);
      instr_q <= NOP_INSTR;
      skid_pc_q <= '0;
      skid_instr_q <= NOP_INSTR;
      cnt_q <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      pc_q <= pc_d;
      pcn_q <= pcn_d;
      instr_q <= instr_d;
      skid_pc_q <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready = ~skid_v_q;
  assign out_valid = main_v_q;
  assign out_pc = pc_q;
  assign out_pc_next = pcn_q;
  assign out_instr = instr_q;
  assign stall_count = cnt_q;
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: directed + short random stimulus checked every cycle against a two-entry FIFO model.
module tb_if_id_skid_reg;
  localparam int PW = 8, IW = 32, INC = 4, CW = 3;
  localparam logic [IW-1:0] NOP = 32'h0000_0013;
  typedef struct {logic [PW-1:0] pc; logic [IW-1:0] instr;} ent_t;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [PW-1:0] in_pc = '0;
  logic [IW-1:0] in_instr = '0;
  logic in_ready, out_valid;
  logic [PW-1:0] out_pc, out_pc_next;
  logic [IW-1:0] out_instr;
  logic [CW-1:0] stall_count;
  int checks = 0, passed = 0;
  ent_t q[$];
  logic [PW-1:0] last_pc;
  int stall;
  bit model_ok = 0;
  if_id_skid_reg #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .PC_INC(INC), .NOP_INSTR(NOP), .CNT_WIDTH(CW)) dut (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .out_instr(out_instr), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      last_pc = '0;
      stall = 0;
      model_ok = 1;
    end else begin
      bit ox, ix;
      ox = q.size() > 0 && out_ready;
      ix = in_valid && q.size() < 2;
      if (q.size() > 0 && !out_ready && stall < (1 << CW) - 1) stall++;
      if (flush) q.delete();
      else begin
        if (ox) void'(q.pop_front());
        if (ix) q.push_back('{in_pc, in_instr});
      end
      if (q.size() > 0) last_pc = q[0].pc;
    end
  end
  always @(negedge clk) if (model_ok) begin
    chk("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("m_in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("m_out_pc", 64'(out_pc), 64'(last_pc));
    chk("m_out_pc_next", 64'(out_pc_next), 64'(PW'(last_pc + PW'(INC))));
    chk("m_out_instr", 64'(out_instr), 64'(q.size() > 0 ? q[0].instr : NOP));
    chk("m_stall", 64'(stall_count), 64'(stall));
  end
  task automatic step(input logic r, input logic v, input logic [PW-1:0] pc, input logic ordy, input logic fl);
    rst = r; in_valid = v; in_pc = pc; in_instr = {24'hC0FFEE, pc}; out_ready = ordy; flush = fl;
    @(negedge clk);
  endtask
  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_ready", 64'(in_ready), 1);
    chk("rst_instr", 64'(out_instr), 64'(NOP));
    chk("rst_pcn", 64'(out_pc_next), 4);
    step(0, 1, 8'h20, 1, 0);
    chk("s_valid", 64'(out_valid), 1);
    chk("s_pc0", 64'(out_pc), 8'h20);
    step(0, 1, 8'h24, 1, 0);
    chk("s_pc1", 64'(out_pc), 8'h24);
    step(0, 1, 8'h28, 1, 0);
    chk("s_pc2", 64'(out_pc), 8'h28);
    chk("s_pcn2", 64'(out_pc_next), 8'h2C);
    chk("s_ready", 64'(in_ready), 1);
    step(0, 0, 0, 1, 0);
    chk("drain_instr", 64'(out_instr), 64'(NOP));
    step(0, 1, 8'h40, 0, 0);
    step(0, 1, 8'h44, 0, 0);
    chk("bp_ready", 64'(in_ready), 0);
    chk("bp_pc", 64'(out_pc), 8'h40);
    step(0, 1, 8'h48, 0, 0);
    chk("bp_hold", 64'(out_pc), 8'h40);
    step(0, 1, 8'h48, 1, 0);
    chk("bp_skid", 64'(out_pc), 8'h44);
    step(0, 1, 8'h48, 1, 0);
    chk("bp_last", 64'(out_pc), 8'h48);
    step(0, 0, 0, 1, 0);
    chk("bp_empty", 64'(out_valid), 0);
    step(0, 1, 8'h50, 0, 0);
    step(0, 1, 8'h54, 0, 0);
    step(0, 1, 8'h58, 1, 1);
    chk("fl_valid", 64'(out_valid), 0);
    chk("fl_instr", 64'(out_instr), 64'(NOP));
    chk("fl_ready", 64'(in_ready), 1);
    chk("fl_pc_hold", 64'(out_pc), 8'h50);
    step(0, 0, 0, 1, 0);
    chk("fl_no58", 64'(out_valid), 0);
    step(0, 1, 8'hFC, 1, 0);
    chk("wrap_pc", 64'(out_pc), 8'hFC);
    chk("wrap_pcn", 64'(out_pc_next), 8'h00);
    step(1, 0, 0, 0, 0);
    step(0, 1, 8'h70, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0);
    chk("stall5", 64'(stall_count), 5);
    repeat (5) step(0, 0, 0, 0, 0);
    chk("stall_sat", 64'(stall_count), 7);
    step(0, 0, 0, 0, 1);
    chk("stall_flush", 64'(stall_count), 7);
    step(0, 1, 8'h80, 0, 0);
    step(0, 1, 8'h84, 0, 0);
    chk("mid_full", 64'(in_ready), 0);
    step(1, 1, 8'h88, 0, 0);
    chk("mid_valid", 64'(out_valid), 0);
    chk("mid_ready", 64'(in_ready), 1);
    chk("mid_instr", 64'(out_instr), 64'(NOP));
    chk("mid_stall", 64'(stall_count), 0);
    for (int i = 0; i < 200; i++)
      step(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
